cordic_rotate_seq: RTL and testbench

Iterative (one micro-rotation per clock) CORDIC rotation-mode engine that rotates a signed vector (x, y) by a binary angle z. It is the sequential stage wrapped around the load/feedback 2-to-1 selection: in IDLE the iteration registers take the external operands, and in RUN they take the previous micro-rotation result. It sits between the operand source and the result consumer, with valid/ready handshakes on both sides.

---
 rtl/cordic_pkg.sv | 44 ++++
 rtl/cordic_micro_rot.sv | 38 +++
 rtl/cordic_rotate_seq.sv | 148 ++++++++++++++
 tb/tb_cordic_rotate_seq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the iterative CORDIC rotation engine: 16-bit
// arctangent table, FSM state encoding, and helpers for angle scaling/clamping.
package cordic_pkg;

    localparam int ATAN_N = 15;

    // atan(2^-i) with a full turn mapped onto 2^16
    localparam logic [15:0] ATAN16 [0:ATAN_N-1] = '{
        16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651,
        16'd326,  16'd163,  16'd81,   16'd41,   16'd20,
        16'd10,   16'd5,    16'd3,    16'd1,    16'd1
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Rescale a table entry to a width-bit angle, rounding to nearest.
    function automatic logic [15:0] atan_scaled(input logic [3:0] idx, input int width);
        logic [16:0] sum;
        sum = {1'b0, ATAN16[idx]} + ((width < 16) ? (17'd1 << (15 - width)) : 17'd0);
        return 16'(sum >> (16 - width));
    endfunction

    // Clamp an 18-bit signed value into the signed range of a width-bit word.
    function automatic logic signed [15:0] sat_clamp(input logic signed [17:0] v,
                                                     input int width);
        logic signed [17:0] hi;
        logic signed [17:0] lo;
        logic signed [17:0] res;
        hi  = (18'sd1 <<< (width - 1)) - 18'sd1;
        lo  = -(18'sd1 <<< (width - 1));
        res = v;
        if (v > hi) begin
            res = hi;
        end else if (v < lo) begin
            res = lo;
        end
        return 16'(res);
    endfunction

endpackage

// File: rtl/cordic_micro_rot.sv
// One combinational CORDIC rotation-mode micro-rotation: rotates (x, y) by
// +/-atan(2^-i) depending on the sign of the residual angle z.
module cordic_micro_rot
    import cordic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IW    = 3
) (
    input  logic signed [WIDTH+1:0] x_cur,
    input  logic signed [WIDTH+1:0] y_cur,
    input  logic signed [WIDTH-1:0] z_cur,
    input  logic        [IW-1:0]    i_cur,
    output logic signed [WIDTH+1:0] x_nxt,
    output logic signed [WIDTH+1:0] y_nxt,
    output logic signed [WIDTH-1:0] z_nxt
);

    logic signed [WIDTH+1:0] x_sh;
    logic signed [WIDTH+1:0] y_sh;
    logic signed [WIDTH-1:0] atan_w;

    always_comb begin
        x_sh   = x_cur >>> i_cur;
        y_sh   = y_cur >>> i_cur;
        atan_w = WIDTH'(atan_scaled(4'(i_cur), WIDTH));
        // z >= 0 drives the vector counter-clockwise; z wraps modulo 2^WIDTH
        if (!z_cur[WIDTH-1]) begin
            x_nxt = x_cur - y_sh;
            y_nxt = y_cur + x_sh;
            z_nxt = z_cur - atan_w;
        end else begin
            x_nxt = x_cur + y_sh;
            y_nxt = y_cur - x_sh;
            z_nxt = z_cur + atan_w;
        end
    end

endmodule

// File: rtl/cordic_rotate_seq.sv
// Sequential CORDIC rotation engine, one micro-rotation per clock, with
// valid/ready on both sides. Optional CORDIC_QUAD_CORR_EN extends range to +/-180 deg.
module cordic_rotate_seq
    import cordic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ITER  = 7
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    in_valid_in,
    output logic                    in_ready_output,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    output logic                    out_valid_output,
    input  logic                    out_ready_in,
    output logic signed [WIDTH-1:0] x_output,
    output logic signed [WIDTH-1:0] y_output
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_I = IW'(ITER - 1);

    state_t state_q;
    state_t state_d;
    logic   load_en;
    logic   step_en;
    logic   done;

    logic signed [WIDTH+1:0] x_p0;
    logic signed [WIDTH+1:0] y_p0;
    logic signed [WIDTH-1:0] z_p0;
    logic        [IW-1:0]    i_p0;

    logic signed [WIDTH+1:0] x_ld;
    logic signed [WIDTH+1:0] y_ld;
    logic signed [WIDTH-1:0] z_ld;

    logic signed [WIDTH+1:0] x_nxt;
    logic signed [WIDTH+1:0] y_nxt;
    logic signed [WIDTH-1:0] z_nxt;

`ifdef CORDIC_QUAD_CORR_EN
    localparam logic signed [WIDTH-1:0] Q_LIM = WIDTH'(1 << (WIDTH - 2));
    localparam logic signed [WIDTH-1:0] HALF  = WIDTH'(1 << (WIDTH - 1));
`endif

    // Operand conditioning at load time
    always_comb begin
        x_ld = (WIDTH + 2)'(x_in);
        y_ld = (WIDTH + 2)'(y_in);
        z_ld = z_in;
`ifdef CORDIC_QUAD_CORR_EN
        // Beyond +/-90 deg: pre-rotate by 180 deg so the iterations converge
        if (z_in > Q_LIM || z_in < -Q_LIM) begin
            x_ld = -x_ld;
            y_ld = -y_ld;
            z_ld = z_in + HALF;
        end
`endif
    end

    cordic_micro_rot #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_micro_rot (
        .x_cur (x_p0),
        .y_cur (y_p0),
        .z_cur (z_p0),
        .i_cur (i_p0),
        .x_nxt (x_nxt),
        .y_nxt (y_nxt),
        .z_nxt (z_nxt)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        in_ready_output  = 1'b0;
        out_valid_output = 1'b0;
        load_en          = 1'b0;
        step_en          = 1'b0;
        done             = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready_output = 1'b1;
                if (in_valid_in) begin
                    load_en = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                step_en = 1'b1;
                if (i_p0 == LAST_I) begin
                    done    = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Returning to IDLE first leaves a one-cycle bubble before the next accept
                out_valid_output = 1'b1;
                if (out_ready_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Iteration registers: load/feedback select, plus result capture on the last step
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            x_p0     <= '0;
            y_p0     <= '0;
            z_p0     <= '0;
            i_p0     <= '0;
            x_output <= '0;
            y_output <= '0;
        end else begin
            if (load_en) begin
                x_p0 <= x_ld;
                y_p0 <= y_ld;
                z_p0 <= z_ld;
                i_p0 <= '0;
            end else if (step_en) begin
                x_p0 <= x_nxt;
                y_p0 <= y_nxt;
                z_p0 <= z_nxt;
                i_p0 <= i_p0 + IW'(1);
            end
            if (done) begin
                x_output <= WIDTH'(sat_clamp(18'(x_nxt), WIDTH));
                y_output <= WIDTH'(sat_clamp(18'(y_nxt), WIDTH));
            end
        end
    end

endmodule

// File: tb/tb_cordic_rotate_seq.sv
// Self-checking bench for cordic_rotate_seq: integer reference model of the
// rotation recurrence, per-cycle output compare, and directed handshake/reset cases.
`timescale 1ns/1ps
module tb_cordic_rotate_seq;

    localparam int WIDTH = 8;
    localparam int ITER  = 7;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic signed [WIDTH-1:0] x_in = '0;
    logic signed [WIDTH-1:0] y_in = '0;
    logic signed [WIDTH-1:0] z_in = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic signed [WIDTH-1:0] x_out;
    logic signed [WIDTH-1:0] y_out;

    int total = 0;
    int bad   = 0;

    int exp_x = 0;
    int exp_y = 0;
    int held_x = 0;
    int held_y = 0;
    bit exp_pending = 1'b0;
    bit rst_pending = 1'b1;

    always #5 clk = ~clk;

    cordic_rotate_seq #(
        .WIDTH (WIDTH),
        .ITER  (ITER)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .in_valid_in      (in_valid),
        .in_ready_output  (in_ready),
        .x_in             (x_in),
        .y_in             (y_in),
        .z_in             (z_in),
        .out_valid_output (out_valid),
        .out_ready_in     (out_ready),
        .x_output         (x_out),
        .y_output         (y_out)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input int act, input int exp, input int tol);
        total++;
        if (act < exp - tol || act > exp + tol) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int wrap_z(input int v);
        int m;
        m = v & ((1 << WIDTH) - 1);
        if (m >= (1 << (WIDTH - 1))) m -= (1 << WIDTH);
        return m;
    endfunction

    function automatic int sat_w(input int v);
        int hi;
        int lo;
        hi = (1 << (WIDTH - 1)) - 1;
        lo = -(1 << (WIDTH - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int atan_ref(input int i);
        real r;
        int  v;
        r = $atan(1.0 / real'(1 << i)) * 65536.0 / (2.0 * 3.14159265358979);
        v = $rtoi(r + 0.5);
        return (v + (1 << (15 - WIDTH))) >>> (16 - WIDTH);
    endfunction

    task automatic model(input int xv, input int yv, input int zv,
                         output int ox, output int oy);
        int x;
        int y;
        int z;
        int nx;
        int ny;
        x = xv;
        y = yv;
        z = wrap_z(zv);
`ifdef CORDIC_QUAD_CORR_EN
        if (z > (1 << (WIDTH - 2)) || z < -(1 << (WIDTH - 2))) begin
            x = -x;
            y = -y;
            z = wrap_z(z + (1 << (WIDTH - 1)));
        end
`endif
        for (int i = 0; i < ITER; i++) begin
            if (z >= 0) begin
                nx = x - (y >>> i);
                ny = y + (x >>> i);
                z  = wrap_z(z - atan_ref(i));
            end else begin
                nx = x + (y >>> i);
                ny = y - (x >>> i);
                z  = wrap_z(z + atan_ref(i));
            end
            x = nx;
            y = ny;
        end
        ox = sat_w(x);
        oy = sat_w(y);
    endtask

    // ---------------- per-cycle output compare ----------------
    always @(negedge clk) begin
        if (rst_pending) begin
            check("reset_out_valid", out_valid, 0);
            check("reset_in_ready", in_ready, 1);
            check("reset_x_out", x_out, 0);
            check("reset_y_out", y_out, 0);
            held_x = 0;
            held_y = 0;
            exp_pending = 1'b0;
        end else if (out_valid) begin
            check("valid_has_op", exp_pending, 1);
            check("result_x", x_out, exp_x);
            check("result_y", y_out, exp_y);
            held_x = exp_x;
            held_y = exp_y;
            if (out_ready) exp_pending = 1'b0;
        end else begin
            check("idle_x_stable", x_out, held_x);
            check("idle_y_stable", y_out, held_y);
        end
        rst_pending = rst;
    end

    // ---------------- directed stimulus ----------------
    task automatic run_op(input int xv, input int yv, input int zv,
                          input int hold, input string tag);
        int ex;
        int ey;
        int lat;
        bit seen;
        model(xv, yv, zv, ex, ey);
        @(posedge clk); #1;
        x_in     = WIDTH'(xv);
        y_in     = WIDTH'(yv);
        z_in     = WIDTH'(zv);
        in_valid = 1'b1;
        @(negedge clk);
        check({tag, "_ready_before"}, in_ready, 1);
        @(posedge clk); #1;
        exp_x       = ex;
        exp_y       = ey;
        exp_pending = 1'b1;
        // keep valid high with different operands: must be ignored until released
        x_in = 8'sd85;
        y_in = -8'sd77;
        z_in = 8'sd50;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check({tag, "_busy_ready"}, in_ready, 0);
            if (out_valid) seen = 1'b1;
        end
        check({tag, "_latency"}, seen ? lat : -1, ITER + 1);
        repeat (hold) begin
            @(negedge clk);
            check({tag, "_held_valid"}, out_valid, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check({tag, "_bubble_ready"}, in_ready, 1);
        check({tag, "_released"}, out_valid, 0);
    endtask

    task automatic reset_mid_run();
        @(posedge clk); #1;
        x_in     = 8'sd60;
        y_in     = 8'sd10;
        z_in     = 8'sd20;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        exp_x       = 999;
        exp_y       = 999;
        exp_pending = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        repeat (ITER + 4) begin
            @(negedge clk);
            check("abort_no_result", out_valid, 0);
        end
    endtask

    initial begin
        int mx;
        int my;
        int atan_tbl [0:6];
        atan_tbl = '{32, 19, 10, 5, 3, 1, 1};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("init_in_ready", in_ready, 1);
        check("init_out_valid", out_valid, 0);
        check("init_x_out", x_out, 0);
        check("init_y_out", y_out, 0);

        // pin the model against hand-derived values
        for (int i = 0; i < ITER; i++) check($sformatf("pin_atan%0d", i), atan_ref(i), atan_tbl[i]);
        model(60, 0, 0, mx, my);
        check_near("pin_rot0_x", mx, 99, 2);
        check_near("pin_rot0_y", my, 0, 2);
        model(50, 0, 32, mx, my);
        check_near("pin_rot45_x", mx, 58, 2);
        check_near("pin_rot45_y", my, 58, 2);
        model(40, 0, -64, mx, my);
        check_near("pin_rotm90_x", mx, 0, 2);
        check_near("pin_rotm90_y", my, -66, 2);
        model(100, 0, 0, mx, my);
        check("pin_sat_x", mx, 127);
        model(-100, 0, 0, mx, my);
        check("pin_satn_x", mx, -128);

        run_op(60, 0, 0, 0, "rot0");
        run_op(50, 0, 32, 2, "rot45");
        run_op(40, 0, -64, 0, "rotm90");
        run_op(100, 0, 0, 5, "sat_pos");
        run_op(-100, 0, 0, 1, "sat_neg");
        run_op(0, 50, 32, 0, "y_axis");
        run_op(-30, 20, -20, 3, "mixed");
        run_op(127, -128, 64, 0, "corner");

        reset_mid_run();
        run_op(20, -40, 10, 0, "recover");

`ifdef CORDIC_QUAD_CORR_EN
        model(40, 0, -128, mx, my);
        check_near("pin_quad_x", mx, -66, 2);
        check_near("pin_quad_y", my, 0, 2);
        run_op(40, 0, -128, 0, "quad180");
        run_op(-50, 30, 100, 0, "quad_pos");
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
